// File: rtl/bcd_entry_pkg.sv
// Shared types and constants for the decimal key-entry block: commit FSM states,
// the largest legal digit and active-low 7-segment codes.
package bcd_entry_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        COMMIT   = 2'd2,
        WAIT_REL = 2'd3
    } entry_state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on the debounced falling edge.
module key_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             press_reg;
    logic             armed_reg;
    logic [1:0]       fill_reg;
    logic [CNT_W-1:0] cnt_reg;

    // A press is only reported once the button has been seen released after
    // reset, so a button held through reset cannot produce a commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            press_reg <= 1'b0;
            armed_reg <= 1'b0;
            fill_reg  <= 2'b00;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn_n;
            sync2_reg <= sync1_reg;
            fill_reg  <= {fill_reg[0], 1'b1};
            press_reg <= 1'b0;
            if (fill_reg[1] && sync2_reg && level_reg) begin
                armed_reg <= 1'b1;
            end
            if (sync2_reg != level_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    level_reg <= sync2_reg;
                    cnt_reg   <= '0;
                    press_reg <= armed_reg & ~sync2_reg;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/bcd_key_entry.sv
// Decimal keypad entry: each debounced press folds SW digit into value*10+digit.
// Optional macro BCD_KEY_ENTRY_ECHO_EN adds HEX_ECHO showing the last committed digit.
module bcd_key_entry
    import bcd_entry_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3,
    parameter int DEB_CYCLES = 500000,
    localparam int CW        = $clog2(MAX_DIGITS + 1)
) (
    input  logic             MAX10_CLK1_50,
    input  logic             RESET_N,
    input  logic [3:0]       DIGIT,
    input  logic             ENTER_N,
    input  logic             CLEAR,
    output logic [WIDTH-1:0] VALUE,
    output logic [CW-1:0]    DIGIT_COUNT,
    output logic             ACCEPT,
    output logic             ERR,
    output logic             OVF
`ifdef BCD_KEY_ENTRY_ECHO_EN
    ,
    output logic [6:0]       HEX_ECHO
`endif
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

    logic             clk;
    logic [4:0]       sw_sync1_reg;
    logic [4:0]       sw_sync2_reg;
    logic             clear_s;
    logic [3:0]       digit_s;
    logic             btn_level;
    logic             press_evt;

    entry_state_t     state_reg;
    logic [3:0]       digit_reg;
    logic [WIDTH-1:0] value_reg;
    logic [CW-1:0]    count_reg;
    logic             accept_reg;
    logic             err_reg;
    logic             ovf_reg;

    logic [WIDTH+3:0] value_ext;
    logic [WIDTH+3:0] prod;
    logic             reject;
    logic             ovf_hit;
    logic             do_commit;

    assign clk = MAX10_CLK1_50;

    // {CLEAR, DIGIT} are plain switch levels; one 2-flop synchronizer per bit.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_sw_sync
            always_ff @(posedge clk) begin
                if (!RESET_N) begin
                    sw_sync1_reg[gi] <= 1'b0;
                    sw_sync2_reg[gi] <= 1'b0;
                end else begin
                    sw_sync1_reg[gi] <= (gi == 4) ? CLEAR : DIGIT[gi % 4];
                    sw_sync2_reg[gi] <= sw_sync1_reg[gi];
                end
            end
        end
    endgenerate

    assign clear_s = sw_sync2_reg[4];
    assign digit_s = sw_sync2_reg[3:0];

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_enter_deb (
        .clk   (clk),
        .rst_n (RESET_N),
        .btn_n (ENTER_N),
        .level (btn_level),
        .press (press_evt)
    );

    // value*10 + digit, wide enough that the overflow test is a simple upper-bit check.
    assign value_ext = {4'b0000, value_reg};
    assign prod      = (value_ext << 3) + (value_ext << 1) + {{WIDTH{1'b0}}, digit_reg};
    assign reject    = (digit_reg > DIGIT_MAX) || (count_reg == MAX_CNT);
    assign ovf_hit   = |prod[WIDTH+3:WIDTH];
    assign do_commit = (state_reg == CHECK) && !clear_s && !reject && !ovf_hit;

    // Commit results are registered on leaving CHECK so they show during COMMIT.
    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            state_reg  <= IDLE;
            digit_reg  <= 4'd0;
            value_reg  <= '0;
            count_reg  <= '0;
            accept_reg <= 1'b0;
            err_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            accept_reg <= 1'b0;
            if (clear_s) begin
                value_reg <= '0;
                count_reg <= '0;
                err_reg   <= 1'b0;
                ovf_reg   <= 1'b0;
                state_reg <= btn_level ? IDLE : WAIT_REL;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (press_evt) begin
                            digit_reg <= digit_s;
                            state_reg <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (reject) begin
                            err_reg   <= 1'b1;
                            state_reg <= WAIT_REL;
                        end else if (ovf_hit) begin
                            ovf_reg   <= 1'b1;
                            state_reg <= WAIT_REL;
                        end else begin
                            value_reg  <= prod[WIDTH-1:0];
                            count_reg  <= count_reg + 1'b1;
                            accept_reg <= 1'b1;
                            state_reg  <= COMMIT;
                        end
                    end
                    COMMIT: begin
                        state_reg <= WAIT_REL;
                    end
                    WAIT_REL: begin
                        if (btn_level) begin
                            state_reg <= IDLE;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign VALUE       = value_reg;
    assign DIGIT_COUNT = count_reg;
    assign ACCEPT      = accept_reg;
    assign ERR         = err_reg;
    assign OVF         = ovf_reg;

`ifdef BCD_KEY_ENTRY_ECHO_EN
    logic [6:0] echo_reg;

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            echo_reg <= SEG_DASH;
        end else if (clear_s) begin
            echo_reg <= SEG_DASH;
        end else if (do_commit) begin
            echo_reg <= seg_digit(digit_reg);
        end
    end

    assign HEX_ECHO = (err_reg || ovf_reg) ? SEG_DASH : echo_reg;
`else
    logic unused_commit;
    assign unused_commit = do_commit;
`endif

endmodule
